div8bit_seq: RTL and testbench

//   Sequential signed divider: the inverse of the calculator's combinational Booth multiplier.
//   - Takes dividend inp1 and divisor inp2 (two's complement).
//   - Produces quotient and remainder by restoring division, one quotient bit per clock.
//   - Start/done handshake; feeds the calculator's result mux alongside the multiplier.

---
 rtl/div8bit_seq.sv | 144 ++++++++++++++
 tb/tb_div8bit_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div8bit_seq.sv
// rtl/div8bit_seq.sv - sequential signed restoring divider with start/done handshake (optional abort via DIV_ABORT_EN)
module div8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
`ifdef DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem;      // partial remainder magnitude, always below the divisor
  logic [WIDTH-1:0] quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH:0]   dvs;      // divisor magnitude, one bit wider so |-2^(WIDTH-1)| fits
  logic [WIDTH-1:0] dvd_raw;  // signed dividend, returned as remainder on divide-by-zero
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             ovf;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             fits;
  logic             abort_req;

  // Operand magnitudes and one restoring-division step
  always_comb begin
    abs_a  = inp1[WIDTH-1] ? (~inp1 + WIDTH'(1)) : inp1;
    abs_b  = inp2[WIDTH-1] ? (~inp2 + WIDTH'(1)) : inp2;
    rem_sh = {rem, quo[WIDTH-1]};
    fits   = (rem_sh >= dvs);
    trial  = WIDTH'(rem_sh - dvs);
`ifdef DIV_ABORT_EN
    abort_req = abort;
`else
    abort_req = 1'b0;
`endif
  end

  // Divider FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      dvd_raw     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      ovf         <= 1'b0;
      res_q       <= '0;
      res_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem     <= '0;
            quo     <= abs_a;
            dvs     <= {1'b0, abs_b};
            dvd_raw <= inp1;
            neg_q   <= inp1[WIDTH-1] ^ inp2[WIDTH-1];
            neg_r   <= inp1[WIDTH-1];
            dz      <= (inp2 == '0);
            ovf     <= (inp1 == {1'b1, {(WIDTH-1){1'b0}}}) && (inp2 == '1);
            cnt     <= 5'(WIDTH);
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (abort_req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem   <= fits ? trial : rem_sh[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], fits};
            cnt   <= cnt - 5'd1;
            if (cnt == 5'd1) state <= FIX;
          end
        end
        FIX: begin
          if (abort_req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (dz) begin
              res_q <= '1;
              res_r <= dvd_raw;
            end else if (ovf) begin
              res_q <= {1'b1, {(WIDTH-1){1'b0}}};
              res_r <= '0;
            end else begin
              res_q <= neg_q ? (~quo + WIDTH'(1)) : quo;
              res_r <= neg_r ? (~rem + WIDTH'(1)) : rem;
            end
            state <= DONE;
          end
        end
        DONE: begin
          quotient    <= res_q;
          remainder   <= res_r;
          div_by_zero <= dz;
          overflow    <= ovf;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div8bit_seq.sv
// tb/tb_div8bit_seq.sv - scoreboard bench for div8bit_seq with directed vectors
module tb_div8bit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] inp1;
  logic [7:0] inp2;
  logic       abort;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  div8bit_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inp1        (inp1),
    .inp2        (inp2),
`ifdef DIV_ABORT_EN
    .abort       (abort),
`endif
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
      end
    end
  end

  // Issue one division, push its expectation and check busy/done timing edge by edge
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] q, input logic [7:0] r,
                     input logic dz, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; inp1 = a; inp2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_T", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k < 10) begin
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
      end else begin
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("done_T10", {31'd0, done}, 32'd1);
      end
    end
    @(posedge clk);
    #1 chk("done_pulse_width", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; inp1 = '0; inp2 = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    run(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);   // 100 / 7
    run(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);   // -100 / 7
    run(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);   // 100 / -7
    run(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);   // -100 / -7
    run(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0);   // 5 / 0
    run(8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0);   // -5 / 0
    run(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);   // -128 / -1
    run(8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0);   // 6 / 3, flags clear
    run(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);   // -128 / 1
    run(8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0);   // 127 / -128
    run(8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);   // -128 / -128
    run(8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0);   // -128 / 127
    run(8'h03, 8'h07, 8'h00, 8'h03, 1'b0, 1'b0);   // 3 / 7

    // Re-pulsed start and operand changes while busy are ignored
    begin
      exp_t e;
      e.q = 8'h0E; e.r = 8'h02; e.dz = 1'b0; e.ov = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; inp1 = 8'h64; inp2 = 8'h07;
      @(posedge clk);                              // T
      #1 start = 1'b0;
      @(posedge clk); @(posedge clk);              // T+2
      @(negedge clk);
      start = 1'b1; inp1 = 8'h09; inp2 = 8'h02;
      @(posedge clk);                              // T+3
      #1 start = 1'b0; inp1 = 8'h11; inp2 = 8'h05;
      repeat (12) @(posedge clk);
      #1;
      chk("single_done_drain", sb.size(), 32'd0);
      chk("q_after_busy_noise", {24'd0, quotient}, 32'h0E);
    end

    // Reset mid-operation aborts with no done and zeroed outputs
    @(negedge clk);
    start = 1'b1; inp1 = 8'h64; inp2 = 8'h07;
    @(posedge clk);                                // T
    #1 start = 1'b0;
    repeat (4) @(posedge clk);                     // T+4
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_quotient", {24'd0, quotient}, 32'd0);
    chk("midrst_remainder", {24'd0, remainder}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

`ifdef DIV_ABORT_EN
    run(8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; inp1 = 8'h64; inp2 = 8'h07;
    @(posedge clk);                                // T
    #1 start = 1'b0;
    repeat (3) @(posedge clk);                     // T+3
    @(negedge clk) abort = 1'b1;
    @(posedge clk);                                // T+4
    #1 abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);                                // T+5
    #1;
    chk("abort_quotient", {24'd0, quotient}, 32'h02);
    chk("abort_remainder", {24'd0, remainder}, 32'h00);
    run(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
